des_key_schedule: RTL and testbench

- Iterative DES key-schedule generator that sits directly upstream of the round function and supplies its 48-bit subkey input.
- Accepts a 64-bit key once, then emits the 16 round subkeys in order, one per accepted handshake: K1..K16 for encrypt, K16..K1 for decrypt.
- Holds only the 56-bit C/D state, not 16 stored subkeys. This lets an iterative DES datapath run one round per cycle.

---
 rtl/des_key_schedule.sv | 164 ++++++++++++++++
 tb/tb_des_key_schedule.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - iterative DES key schedule: one 48-bit subkey per handshake
// Holds only the 56-bit C/D state; each subkey is PC-2 of the rotated state.
module des_key_schedule #(
    parameter bit CHECK_PARITY = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        key_valid,
    output logic        key_ready,
    output logic        key_err,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        last
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Tables use DES numbering (bit 1 = MSB), hence the 64-n / 56-n mapping.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = k[6'(64 - PC1[i])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[6'(47 - i)] = cd[6'(56 - PC2[i])];
        end
        return r;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] v, input logic [1:0] s,
                                          input logic right);
        logic [27:0] r;
        r = v;
        if (right) begin
            if (s == 2'd1)      r = {v[0], v[27:1]};
            else if (s == 2'd2) r = {v[1:0], v[27:2]};
        end else begin
            if (s == 2'd1)      r = {v[26:0], v[27]};
            else if (s == 2'd2) r = {v[25:0], v[27:26]};
        end
        return r;
    endfunction

    function automatic logic parity_ok(input logic [63:0] k);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            ok = ok & (^k[8*b +: 8]);
        end
        return ok;
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dir_q, dir_d;
    logic        key_err_q, key_err_d;

    logic [1:0]  sh;
    logic [27:0] c_nxt, d_nxt;
    logic [47:0] sk;

    // Decrypt presents K16 first, which equals PC-2 of the unrotated state.
    always_comb begin
        sh = 2'd2;
        if (cnt_q == 4'd0 || cnt_q == 4'd1 || cnt_q == 4'd8 || cnt_q == 4'd15) begin
            sh = (dir_q && cnt_q == 4'd0) ? 2'd0 : 2'd1;
        end
    end

    assign c_nxt = rot28(c_q, sh, dir_q);
    assign d_nxt = rot28(d_q, sh, dir_q);
    assign sk    = pc2({c_nxt, d_nxt});

    always_comb begin
        state_d      = state_q;
        c_d          = c_q;
        d_d          = d_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        key_err_d    = 1'b0;
        key_ready    = 1'b0;
        subkey_valid = 1'b0;
        subkey       = '0;
        round_idx    = '0;
        last         = 1'b0;
        case (state_q)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    if (CHECK_PARITY && !parity_ok(key_in)) begin
                        key_err_d = 1'b1;
                    end else begin
                        {c_d, d_d} = pc1(key_in);
                        dir_d      = decrypt;
                        cnt_d      = 4'd0;
                        state_d    = RUN;
                    end
                end
            end
            RUN: begin
                subkey_valid = 1'b1;
                subkey       = sk;
                round_idx    = dir_q ? (4'd15 - cnt_q) : cnt_q;
                last         = (cnt_q == 4'd15);
                if (subkey_ready) begin
                    c_d = c_nxt;
                    d_d = d_nxt;
                    if (cnt_q == 4'd15) begin
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_err = key_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            c_q       <= '0;
            d_q       <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            d_q       <= d_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            key_err_q <= key_err_d;
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - self-checking bench for des_key_schedule
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key_in;
    logic        decrypt;
    logic        key_valid;
    logic        key_ready;
    logic        key_err;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round_idx;
    logic        last;

    always #5 clk = ~clk;

    des_key_schedule #(.CHECK_PARITY(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .decrypt      (decrypt),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_err      (key_err),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .last         (last)
    );

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] SPEC_KEY  = 64'h133457799BBCDFF1;
    localparam logic [63:0] OTHER_KEY = 64'h0123456789ABCDEF;
    localparam logic [63:0] BAD_KEY   = 64'h123457799BBCDFF1;
    localparam logic [47:0] SPEC_K1   = 48'h1B02EFFC7072;
    localparam logic [47:0] SPEC_K2   = 48'h79AED9DBC9E5;
    localparam logic [47:0] SPEC_K16  = 48'hCB3D8B0E17F5;

    typedef struct {
        logic [63:0] key;
        bit          dec;
        int          mode;
        logic [47:0] first;
        logic [47:0] lst;
        bit          use_const;
    } vec_t;

    vec_t        vecs [10];
    logic [47:0] ks [16];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Textbook schedule: bit arrays, per-round left rotations, all 16 keys stored.
    task automatic build_model(input logic [63:0] key);
        int c [28];
        int d [28];
        int cd [56];
        int t;
        logic [47:0] sk;
        for (int i = 0; i < 28; i++) begin
            c[i] = int'((key >> (64 - PC1[i])) & 64'd1);
            d[i] = int'((key >> (64 - PC1[28 + i])) & 64'd1);
        end
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                t = c[0];
                for (int j = 0; j < 27; j++) c[j] = c[j + 1];
                c[27] = t;
                t = d[0];
                for (int j = 0; j < 27; j++) d[j] = d[j + 1];
                d[27] = t;
            end
            for (int j = 0; j < 28; j++) begin
                cd[j]      = c[j];
                cd[28 + j] = d[j];
            end
            sk = '0;
            for (int j = 0; j < 48; j++) sk = (sk << 1) | 48'(cd[PC2[j] - 1]);
            ks[r] = sk;
        end
    endtask

    function automatic logic [63:0] fix_parity(input logic [63:0] k);
        logic [63:0] r;
        logic [7:0]  by;
        r = k;
        for (int b = 0; b < 8; b++) begin
            by        = r[8*b +: 8];
            by[0]     = ~^by[7:1];
            r[8*b +: 8] = by;
        end
        return r;
    endfunction

    function automatic vec_t mkvec(input logic [63:0] key, input bit dec, input int mode,
                                   input logic [47:0] first, input logic [47:0] lst,
                                   input bit use_const);
        vec_t v;
        v.key = key; v.dec = dec; v.mode = mode;
        v.first = first; v.lst = lst; v.use_const = use_const;
        return v;
    endfunction

    // modes: 0 ready always, 1 random ready, 2 hold 3 cycles on K2,
    //        3 foreign key offered mid-run, 4 reset after 5 transfers
    task automatic run_seq(input vec_t v);
        int got;
        int budget;
        int held;
        int idx;
        bit rdy;
        build_model(v.key);
        check("key_ready_before", key_ready, 1);
        key_in       = v.key;
        decrypt      = v.dec;
        key_valid    = 1'b1;
        subkey_ready = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        decrypt   = ~v.dec;
        got = 0; budget = 300; held = 0;
        while (got < 16 && budget > 0) begin
            budget--;
            idx = v.dec ? 15 - got : got;
            check("subkey_valid", subkey_valid, 1);
            check("subkey", subkey, ks[idx]);
            check("round_idx", round_idx, idx);
            check("last", last, (got == 15));
            if (v.use_const && got == 0) check("first_const", subkey, v.first);
            if (v.use_const && got == 15) check("last_const", subkey, v.lst);
            if (v.mode == 2 && got == 1) check("k2_const", subkey, SPEC_K2);
            if (v.mode == 4 && got == 5) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check("rst_subkey_valid", subkey_valid, 0);
                check("rst_subkey", subkey, 0);
                check("rst_key_ready", key_ready, 1);
                check("rst_round_idx", round_idx, 0);
                check("rst_last", last, 0);
                return;
            end
            rdy = 1'b1;
            key_valid = 1'b0;
            if (v.mode == 1) rdy = 1'($urandom_range(0, 1));
            if (v.mode == 2 && got == 1 && held < 3) begin
                rdy = 1'b0;
                held++;
            end
            if (v.mode == 3 && (got == 5 || got == 6)) begin
                check("key_ready_in_run", key_ready, 0);
                key_in    = OTHER_KEY;
                key_valid = 1'b1;
            end
            subkey_ready = rdy;
            @(posedge clk); #1;
            if (rdy) got++;
        end
        key_valid    = 1'b0;
        subkey_ready = 1'b1;
        check("transfers", got, 16);
        check("key_ready_after", key_ready, 1);
        check("subkey_valid_after", subkey_valid, 0);
        check("subkey_after", subkey, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        key_in       = '0;
        decrypt      = 1'b0;
        key_valid    = 1'b0;
        subkey_ready = 1'b1;

        vecs[0] = mkvec(SPEC_KEY, 1'b0, 0, SPEC_K1, SPEC_K16, 1'b1);
        vecs[1] = mkvec(SPEC_KEY, 1'b1, 0, SPEC_K16, SPEC_K1, 1'b1);
        vecs[2] = mkvec(SPEC_KEY, 1'b0, 2, SPEC_K1, SPEC_K16, 1'b1);
        vecs[3] = mkvec(SPEC_KEY, 1'b0, 3, SPEC_K1, SPEC_K16, 1'b1);
        vecs[4] = mkvec(SPEC_KEY, 1'b0, 4, SPEC_K1, SPEC_K16, 1'b1);
        vecs[5] = mkvec(SPEC_KEY, 1'b0, 0, SPEC_K1, SPEC_K16, 1'b1);
        for (int i = 6; i < 10; i++) begin
            vecs[i] = mkvec(fix_parity({$urandom, $urandom}), 1'($urandom_range(0, 1)),
                            1, '0, '0, 1'b0);
        end

        repeat (2) @(posedge clk);
        #1;
        check("reset_key_ready", key_ready, 1);
        check("reset_key_err", key_err, 0);
        check("reset_subkey_valid", subkey_valid, 0);
        check("reset_subkey", subkey, 0);
        check("reset_round_idx", round_idx, 0);
        check("reset_last", last, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_seq(vecs[i]);

        key_in    = BAD_KEY;
        decrypt   = 1'b0;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        check("parity_key_err", key_err, 1);
        check("parity_key_ready", key_ready, 1);
        check("parity_subkey_valid", subkey_valid, 0);
        @(posedge clk); #1;
        check("parity_key_err_pulse", key_err, 0);
        check("parity_subkey_valid2", subkey_valid, 0);
        check("parity_key_ready2", key_ready, 1);
        run_seq(mkvec(SPEC_KEY, 1'b0, 0, SPEC_K1, SPEC_K16, 1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
